abacus_shared_act_tracker: RTL
==============================

// Module: abacus_shared_act_tracker
// PURPOSE
//  Row-activation tracker shared across all banks of one rank: a table of N_ENTRY rows.
//  Each entry holds a shared count and a per-bank sibling mask.
//  A spillover counter tracks untracked rows.
//  When a row or the spillover counter reaches RH_THRESHOLD, the block issues a mitigation request.
//  Sits beside the command scheduler, which sends every ACT to it and stalls on backpressure.
//  This parametrised successor of the ACT control FSM keeps its table in-block, adds ready/valid
//  handshakes, the bank mask, threshold mitigation and window reset.
// PARAMETERS
//  ROW_ADDR_BIT  16   row address width
//  N_BANKS       16   banks sharing the table; BANK_W = $clog2(N_BANKS) (min 1)
//  N_ENTRY       32   tracked rows; IDX_W = $clog2(N_ENTRY)
//  RH_THRESHOLD  512  activation count that triggers mitigation; CNT_W = $clog2(RH_THRESHOLD+1)
// PORTS
//  clk_i        in   1             clock
//  rst_i        in   1             async active-high reset
//  act_valid_i  in   1             ACT offered
//  act_ready_o  out  1             ACT accepted when valid&ready
//  act_row_i    in   ROW_ADDR_BIT  activated row
//  act_bank_i   in   BANK_W        activated bank
//  win_rst_i    in   1             refresh-window pulse: clear all tracking state
//  mit_valid_o  out  1             mitigation request
//  mit_ready_i  in   1             mitigation accepted
//  mit_all_o    out  1             1 = spillover overflow (refresh all rows), 0 = row mitigation
//  mit_row_o    out  ROW_ADDR_BIT  aggressor row; 0 when mit_all_o
//  sp_cnt_o     out  CNT_W         spillover counter value
//  busy_o       out  1             state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, all entries invalid, counts/masks 0, sp_cnt=0, win pending=0.
//   Reset values: mit_valid_o=0, mit_all_o=0, mit_row_o=0, act_ready_o=0 while rst_i is high,
//   then 1 once rst_i is low.
//  FSM states: IDLE, LOOKUP, UPDATE, MITIGATE, CLEAR.
//   IDLE: act_ready_o=!win_pend. If win_pend -> CLEAR. Else if accept, latch row/bank -> LOOKUP.
//   LOOKUP: register addr match (valid & row equal; at most one). Register victim index.
//    Victim = lowest-index invalid entry, else lowest-index entry with count==sp_cnt.
//   UPDATE, row hit at idx i:
//    mask[i][bank]=1 -> c=count+1, mask=onehot(bank); else mask|=onehot(bank), count unchanged.
//    If c>=RH_THRESHOLD: latch mit_row=row, count[i]=sp_cnt, mask[i]=0 -> MITIGATE.
//    Else write c -> IDLE.
//   UPDATE, miss with victim v: row[v]=row, valid=1, count=sp_cnt+1, mask=onehot(bank).
//    Same threshold check as hit.
//   UPDATE, miss with no victim: sp_cnt+1.
//    If sp_cnt+1>=RH_THRESHOLD -> MITIGATE with mit_all; else -> IDLE.
//   MITIGATE: mit_valid_o=1; mit_all_o and mit_row_o held stable until mit_ready_i.
//    On ack: mit_all -> CLEAR; row -> IDLE.
//   CLEAR: one cycle; all valid=0, counts/masks=0, sp_cnt=0, win_pend=0 -> IDLE.
//  Latency: accept at cycle 0; ready again at cycle 3 without mitigation (1 ACT per 3 cycles).
//  Counts never exceed RH_THRESHOLD, with no wrap-around; comparisons are at CNT_W.
//  Entry counts are always >= sp_cnt; a replacement victim count equals sp_cnt.
//  win_rst_i in any state sets win_pend. An in-flight ACT and mitigation complete first,
//   then CLEAR runs from IDLE.
//  win_rst_i together with act_valid_i in IDLE: the window wins; the ACT waits and is not accepted.
//  win_rst_i during CLEAR: that CLEAR clears win_pend; the new pulse is absorbed.
//  Reset asserted mid-operation: every state returns to reset values at once and the pending
//   mitigation is dropped.
// STRUCTURE
//  Package abacus_pkg: state enum, CNT_W/IDX_W/BANK_W helper functions, entry struct {valid, row, count, mask}.
//  Sub-module abacus_match_unit (combinational): row CAM compare, plus first-invalid and
//   first-count-equal priority encoders; outputs hit, hit_idx, vic_ok, vic_idx.
//  Top: FSM, table registers, sp_cnt, win_pend, mitigation output registers.
// TESTING (N_ENTRY=4, N_BANKS=2, RH_THRESHOLD=4)
//  1. ACT row 5 bank 0 -> entry0 = {5, count 1, mask 01}; act_ready_o low 2 cycles, high on cycle 3.
//  2. Row 5 activated on banks 0,1,0,1 -> count 1->1->2->2.
//     Further ACTs on bank 0 -> count 3, then 4 -> mit_valid_o=1, mit_row_o=5, mit_all_o=0.
//     Hold mit_ready_i=0 for 5 cycles: request stays stable, act_ready_o=0; ack -> IDLE.
//  3. Fill 4 entries with count 2, then ACT a new row -> sp_cnt_o=1 and no replacement.
//     Next new rows push sp_cnt toward the threshold: sp_cnt=2 means entries equal sp_cnt,
//     so the next new row replaces entry0 with count 3.
//  4. Spillover reaches 4 -> mit_all_o=1 with mit_row_o=0; after ack, CLEAR empties the table
//     and sp_cnt_o=0.
//  5. win_rst_i in the same IDLE cycle as act_valid_i: no accept; CLEAR runs next, then the ACT
//     is accepted. win_rst_i during UPDATE: the ACT completes, then CLEAR runs.
//  6. Assert rst_i while in MITIGATE: mit_valid_o=0 immediately, table empty, sp_cnt_o=0.

Source files
------------

// File: rtl/abacus_pkg.sv
// Shared types and width helpers for the shared row-activation tracker.
package abacus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_MITIGATE,
    ST_CLEAR
  } state_e;

  function automatic int cnt_w(input int threshold);
    return $clog2(threshold + 1);
  endfunction

  function automatic int idx_w(input int n_entry);
    return (n_entry > 1) ? $clog2(n_entry) : 1;
  endfunction

  function automatic int bank_w(input int n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

endpackage

// File: rtl/abacus_match_unit.sv
// Combinational row CAM plus victim selection: lowest invalid entry, else lowest
// valid entry whose count equals the spillover count.
module abacus_match_unit
  import abacus_pkg::*;
#(
  parameter  int ROW_W   = 16,
  parameter  int N_ENTRY = 32,
  parameter  int CNT_W   = 10,
  localparam int IDX_W   = idx_w(N_ENTRY)
) (
  input  logic [N_ENTRY-1:0] valid_i,
  input  logic [ROW_W-1:0]   row_tab_i [N_ENTRY],
  input  logic [CNT_W-1:0]   cnt_tab_i [N_ENTRY],
  input  logic [ROW_W-1:0]   row_i,
  input  logic [CNT_W-1:0]   sp_cnt_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o,
  output logic               vic_ok_o,
  output logic [IDX_W-1:0]   vic_idx_o
);

  logic             inv_ok, eq_ok;
  logic [IDX_W-1:0] inv_idx, eq_idx;

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    inv_ok    = 1'b0;
    inv_idx   = '0;
    eq_ok     = 1'b0;
    eq_idx    = '0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (valid_i[i] && (row_tab_i[i] == row_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!valid_i[i]) begin
        inv_ok  = 1'b1;
        inv_idx = IDX_W'(i);
      end
      if (valid_i[i] && (cnt_tab_i[i] == sp_cnt_i)) begin
        eq_ok  = 1'b1;
        eq_idx = IDX_W'(i);
      end
    end
    vic_ok_o  = inv_ok | eq_ok;
    vic_idx_o = inv_ok ? inv_idx : eq_idx;
  end

endmodule

// File: rtl/abacus_shared_act_tracker.sv
// Rank-wide ACT tracker: shared row table with per-bank sibling masks, spillover
// counter, threshold mitigation requests and refresh-window clear.
module abacus_shared_act_tracker
  import abacus_pkg::*;
#(
  parameter  int ROW_ADDR_BIT = 16,
  parameter  int N_BANKS      = 16,
  parameter  int N_ENTRY      = 32,
  parameter  int RH_THRESHOLD = 512,
  localparam int BANK_W       = bank_w(N_BANKS),
  localparam int IDX_W        = idx_w(N_ENTRY),
  localparam int CNT_W        = cnt_w(RH_THRESHOLD)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    act_valid_i,
  output logic                    act_ready_o,
  input  logic [ROW_ADDR_BIT-1:0] act_row_i,
  input  logic [BANK_W-1:0]       act_bank_i,
  input  logic                    win_rst_i,
  output logic                    mit_valid_o,
  input  logic                    mit_ready_i,
  output logic                    mit_all_o,
  output logic [ROW_ADDR_BIT-1:0] mit_row_o,
  output logic [CNT_W-1:0]        sp_cnt_o,
  output logic                    busy_o
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(RH_THRESHOLD);

  typedef struct packed {
    logic                    valid;
    logic [ROW_ADDR_BIT-1:0] row;
    logic [CNT_W-1:0]        count;
    logic [N_BANKS-1:0]      mask;
  } entry_t;

  state_e                  state_q, state_d;
  entry_t                  tab_q [N_ENTRY];
  entry_t                  tab_d [N_ENTRY];
  logic [CNT_W-1:0]        sp_q, sp_d;
  logic                    win_pend_q, win_pend_d;
  logic [ROW_ADDR_BIT-1:0] row_lat_q, row_lat_d;
  logic [BANK_W-1:0]       bank_lat_q, bank_lat_d;
  logic                    hit_q, hit_d, vic_ok_q, vic_ok_d;
  logic [IDX_W-1:0]        hit_idx_q, hit_idx_d, vic_idx_q, vic_idx_d;
  logic                    mit_all_q, mit_all_d;
  logic [ROW_ADDR_BIT-1:0] mit_row_q, mit_row_d;

  logic [N_ENTRY-1:0]      valid_vec;
  logic [ROW_ADDR_BIT-1:0] row_tab [N_ENTRY];
  logic [CNT_W-1:0]        cnt_tab [N_ENTRY];
  logic                    m_hit, m_vic_ok;
  logic [IDX_W-1:0]        m_hit_idx, m_vic_idx;
  logic [N_BANKS-1:0]      bank_oh, mask_new;
  logic [CNT_W-1:0]        cnt_new;
  logic [IDX_W-1:0]        upd_idx;
  logic                    upd_mit, act_fire;

  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      valid_vec[i] = tab_q[i].valid;
      row_tab[i]   = tab_q[i].row;
      cnt_tab[i]   = tab_q[i].count;
    end
  end

  abacus_match_unit #(
    .ROW_W   (ROW_ADDR_BIT),
    .N_ENTRY (N_ENTRY),
    .CNT_W   (CNT_W)
  ) u_match (
    .valid_i   (valid_vec),
    .row_tab_i (row_tab),
    .cnt_tab_i (cnt_tab),
    .row_i     (row_lat_q),
    .sp_cnt_i  (sp_q),
    .hit_o     (m_hit),
    .hit_idx_o (m_hit_idx),
    .vic_ok_o  (m_vic_ok),
    .vic_idx_o (m_vic_idx)
  );

  assign bank_oh  = N_BANKS'(1) << bank_lat_q;
  assign act_fire = act_valid_i & act_ready_o;

  // Datapath: table, spillover, latched ACT, lookup result, mitigation payload.
  always_comb begin
    tab_d      = tab_q;
    sp_d       = sp_q;
    row_lat_d  = row_lat_q;
    bank_lat_d = bank_lat_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    vic_ok_d   = vic_ok_q;
    vic_idx_d  = vic_idx_q;
    mit_all_d  = mit_all_q;
    mit_row_d  = mit_row_q;
    cnt_new    = sp_q + 1'b1;
    mask_new   = bank_oh;
    upd_idx    = vic_idx_q;
    upd_mit    = 1'b0;
    win_pend_d = (state_q == ST_CLEAR) ? 1'b0 : (win_pend_q | win_rst_i);
    case (state_q)
      ST_IDLE: begin
        if (act_fire) begin
          row_lat_d  = act_row_i;
          bank_lat_d = act_bank_i;
        end
      end
      ST_LOOKUP: begin
        hit_d     = m_hit;
        hit_idx_d = m_hit_idx;
        vic_ok_d  = m_vic_ok;
        vic_idx_d = m_vic_idx;
      end
      ST_UPDATE: begin
        if (hit_q) begin
          upd_idx = hit_idx_q;
          // A repeat on a bank already in the mask is a new activation of the row.
          if (tab_q[hit_idx_q].mask[bank_lat_q]) begin
            cnt_new = tab_q[hit_idx_q].count + 1'b1;
          end else begin
            cnt_new  = tab_q[hit_idx_q].count;
            mask_new = tab_q[hit_idx_q].mask | bank_oh;
          end
        end
        if (hit_q || vic_ok_q) begin
          tab_d[upd_idx].valid = 1'b1;
          tab_d[upd_idx].row   = row_lat_q;
          if (cnt_new >= THR) begin
            upd_mit              = 1'b1;
            tab_d[upd_idx].count = sp_q;
            tab_d[upd_idx].mask  = '0;
            mit_all_d            = 1'b0;
            mit_row_d            = row_lat_q;
          end else begin
            tab_d[upd_idx].count = cnt_new;
            tab_d[upd_idx].mask  = mask_new;
          end
        end else begin
          sp_d = cnt_new;
          if (cnt_new >= THR) begin
            upd_mit   = 1'b1;
            mit_all_d = 1'b1;
            mit_row_d = '0;
          end
        end
      end
      ST_MITIGATE: begin
        if (mit_ready_i) begin
          mit_all_d = 1'b0;
          mit_row_d = '0;
        end
      end
      ST_CLEAR: begin
        for (int i = 0; i < N_ENTRY; i++) tab_d[i] = '0;
        sp_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (win_pend_q || win_rst_i) state_d = ST_CLEAR;
                   else if (act_fire)           state_d = ST_LOOKUP;
      ST_LOOKUP:   state_d = ST_UPDATE;
      ST_UPDATE:   state_d = upd_mit ? ST_MITIGATE : ST_IDLE;
      ST_MITIGATE: if (mit_ready_i) state_d = mit_all_q ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    act_ready_o = !rst_i && (state_q == ST_IDLE) && !win_pend_q && !win_rst_i;
    mit_valid_o = (state_q == ST_MITIGATE);
    busy_o      = (state_q != ST_IDLE);
    mit_all_o   = mit_all_q;
    mit_row_o   = mit_row_q;
    sp_cnt_o    = sp_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < N_ENTRY; i++) tab_q[i] <= '0;
      sp_q       <= '0;
      win_pend_q <= 1'b0;
      row_lat_q  <= '0;
      bank_lat_q <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      vic_ok_q   <= 1'b0;
      vic_idx_q  <= '0;
      mit_all_q  <= 1'b0;
      mit_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      tab_q      <= tab_d;
      sp_q       <= sp_d;
      win_pend_q <= win_pend_d;
      row_lat_q  <= row_lat_d;
      bank_lat_q <= bank_lat_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      vic_ok_q   <= vic_ok_d;
      vic_idx_q  <= vic_idx_d;
      mit_all_q  <= mit_all_d;
      mit_row_q  <= mit_row_d;
    end
  end

endmodule
